// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one physical SPI bus between two SPI master cores.
// Requester 0 and requester 1 use a req/gnt handshake. Ties are broken
// round-robin. A guard gap of idle clocks follows every release. The bus sits
// at its idle levels whenever nobody owns it.
// Optional feature macro: SPI_BUS_ARBITER_TIMEOUT_EN. When it is defined, a
// watchdog revokes any grant that lasts TIMEOUT_CYC clocks and sets the
// sticky timeout_flag.
module spi_bus_arbiter #(
  parameter int SS0_W       = 2,
  parameter int SS1_W       = 3,
  parameter bit CPOL        = 1'b0,
  parameter int GUARD_CYC   = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  output logic [1:0]             gnt,
  input  logic                   m0_sclk,
  input  logic                   m0_mosi,
  input  logic [SS0_W-1:0]       m0_ss_n,
  output logic                   m0_miso,
  input  logic                   m1_sclk,
  input  logic                   m1_mosi,
  input  logic [SS1_W-1:0]       m1_ss_n,
  output logic                   m1_miso,
  output logic                   bus_sclk,
  output logic                   bus_mosi,
  input  logic                   bus_miso,
  output logic [SS0_W+SS1_W-1:0] bus_ss_n,
  output logic [1:0]             owner,
  output logic                   timeout_flag
);

  // Out-of-range configurations are rejected at elaboration time.
  if (GUARD_CYC < 1 || GUARD_CYC > 255) begin : g_bad_guard
    $error("spi_bus_arbiter: GUARD_CYC must be in 1..255");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("spi_bus_arbiter: TIMEOUT_CYC must be in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN0  = 2'd1,
    S_OWN1  = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYC - 1);

  state_t     state, state_nxt;
  logic       last, last_nxt;        // 0: requester 0 owned last, 1: requester 1
  logic [7:0] guard_cnt, guard_nxt;
  logic       rel0, rel1;            // owner has finished its transfer
  logic       wdog_hit;              // grant has reached its length limit

  // The owner releases only when it has dropped req and all of its selects
  // are high. The two conditions are sampled in the same clock, so a transfer
  // that is still running keeps the bus.
  assign rel0 = ~req[0] & (&m0_ss_n);
  assign rel1 = ~req[1] & (&m1_ss_n);

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wdog;
  logic        to_flag;
  logic        owned;

  assign owned    = (state == S_OWN0) || (state == S_OWN1);
  assign wdog_hit = owned && (wdog == TIMEOUT_LAST);

  // Watchdog counts owned clocks. It rests at zero outside ownership, so every
  // grant starts counting from zero. The flag stays set until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog    <= '0;
      to_flag <= 1'b0;
    end else begin
      wdog <= owned ? wdog + 16'd1 : 16'd0;
      if (wdog_hit) to_flag <= 1'b1;
    end
  end

  assign timeout_flag = to_flag;
`else
  assign wdog_hit     = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // State register plus registered gnt/owner, which decode the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: only control registers exist here, and each one gets an explicit
      // async reset value. Reset forces state to IDLE, so the bus mux below
      // drops to idle levels asynchronously.
      state     <= S_IDLE;
      last      <= 1'b1;
      guard_cnt <= '0;
      gnt       <= 2'b00;
      owner     <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then updates from values sampled before the edge.
      state     <= state_nxt;
      last      <= last_nxt;
      guard_cnt <= guard_nxt;
      gnt       <= {state_nxt == S_OWN1, state_nxt == S_OWN0};
      owner     <= {state_nxt == S_OWN1, state_nxt == S_OWN0};
    end
  end

  // Next-state logic: arbitration in IDLE, release/timeout in OWNx, gap count.
  always_comb begin
    // NOTE: every signal gets a default first. The paths that do not assign a
    // value then hold it, and no latch is inferred.
    state_nxt = state;
    last_nxt  = last;
    guard_nxt = guard_cnt;
    unique case (state)
      S_IDLE: begin
        unique case (req)
          2'b01:   state_nxt = S_OWN0;
          2'b10:   state_nxt = S_OWN1;
          2'b11:   state_nxt = last ? S_OWN0 : S_OWN1;
          default: state_nxt = S_IDLE;
        endcase
      end
      S_OWN0: begin
        if (rel0 || wdog_hit) begin
          state_nxt = S_GUARD;
          last_nxt  = 1'b0;
          guard_nxt = GUARD_LOAD;
        end
      end
      S_OWN1: begin
        if (rel1 || wdog_hit) begin
          state_nxt = S_GUARD;
          last_nxt  = 1'b1;
          guard_nxt = GUARD_LOAD;
        end
      end
      S_GUARD: begin
        if (guard_cnt == 8'd0) state_nxt = S_IDLE;
        else                   guard_nxt = guard_cnt - 8'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus data path: a zero-latency mux from the owner, idle levels otherwise.
  // The non-owner's selects are forced high, and its MISO is held at 0.
  always_comb begin
    bus_sclk = CPOL;
    bus_mosi = 1'b0;
    bus_ss_n = '1;
    m0_miso  = 1'b0;
    m1_miso  = 1'b0;
    unique case (state)
      S_OWN0: begin
        bus_sclk = m0_sclk;
        bus_mosi = m0_mosi;
        bus_ss_n = {{SS1_W{1'b1}}, m0_ss_n};
        m0_miso  = bus_miso;
      end
      S_OWN1: begin
        bus_sclk = m1_sclk;
        bus_mosi = m1_mosi;
        bus_ss_n = {m1_ss_n, {SS0_W{1'b1}}};
        m1_miso  = bus_miso;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed testbench for spi_bus_arbiter, using GUARD_CYC=4, CPOL=0 and
// TIMEOUT_CYC=16. The timeout steps depend on SPI_BUS_ARBITER_TIMEOUT_EN.
module tb_spi_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       m0_sclk, m0_mosi, m0_miso;
  logic [1:0] m0_ss_n;
  logic       m1_sclk, m1_mosi, m1_miso;
  logic [2:0] m1_ss_n;
  logic       bus_sclk, bus_mosi, bus_miso;
  logic [4:0] bus_ss_n;
  logic [1:0] owner;
  logic       timeout_flag;

  int vectors     = 0;
  int miscompares = 0;

  spi_bus_arbiter #(
    .SS0_W(2), .SS1_W(3), .CPOL(1'b0), .GUARD_CYC(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .m0_sclk(m0_sclk), .m0_mosi(m0_mosi), .m0_ss_n(m0_ss_n), .m0_miso(m0_miso),
    .m1_sclk(m1_sclk), .m1_mosi(m1_mosi), .m1_ss_n(m1_ss_n), .m1_miso(m1_miso),
    .bus_sclk(bus_sclk), .bus_mosi(bus_mosi), .bus_miso(bus_miso),
    .bus_ss_n(bus_ss_n), .owner(owner), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge. Stimulus and sampling happen 2ns after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; req = 2'b00; bus_miso = 1'b0;
    m0_sclk = 1'b0; m0_mosi = 1'b0; m0_ss_n = 2'b11;
    m1_sclk = 1'b0; m1_mosi = 1'b0; m1_ss_n = 3'b111;
    #3;
    check("rst_gnt", gnt, 2'b00);
    check("rst_owner", owner, 2'b00);
    check("rst_ss", bus_ss_n, 5'b11111);
    check("rst_sclk", bus_sclk, 1'b0);
    check("rst_mosi", bus_mosi, 1'b0);
    check("rst_miso", {m1_miso, m0_miso}, 2'b00);
    check("rst_flag", timeout_flag, 1'b0);
    #11 rst = 1'b1;

    // Single request from requester 0: the grant appears one clock later.
    step();
    req = 2'b01; #1;
    check("t1_pre_gnt", gnt, 2'b00);
    step();
    check("t1_gnt", gnt, 2'b01);
    check("t1_owner", owner, 2'b01);
    check("t1_ss_idle", bus_ss_n, 5'b11111);
    m0_ss_n = 2'b10; m0_sclk = 1'b1; m0_mosi = 1'b1; bus_miso = 1'b1; #1;
    check("t1_ss_sel", bus_ss_n, 5'b11110);
    check("t1_sclk", bus_sclk, 1'b1);
    check("t1_mosi", bus_mosi, 1'b1);
    check("t1_miso", {m1_miso, m0_miso}, 2'b01);

    // Dropping req mid-transfer does not cut the transfer.
    req = 2'b00;
    step(); check("t2_hold_a", gnt, 2'b01);
    step(); check("t2_hold_b", gnt, 2'b01);
    m0_ss_n = 2'b11; m0_sclk = 1'b0; m0_mosi = 1'b0; bus_miso = 1'b0;
    step();
    check("t2_rel_gnt", gnt, 2'b00);
    check("t2_rel_owner", owner, 2'b00);
    // Guard gap: requests and an unauthorised select are both ignored.
    req = 2'b01; m0_ss_n = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t2_guard_gnt%0d", i), gnt, 2'b00);
      check($sformatf("t2_guard_ss%0d", i), bus_ss_n, 5'b11111);
    end
    step();
    check("t2_regrant", gnt, 2'b01);
    check("t2_regrant_ss", bus_ss_n, 5'b11100);
    m0_ss_n = 2'b11; req = 2'b00;
    step();
    check("t2_rel2", gnt, 2'b00);

    // Round-robin, starting from reset.
    rst = 1'b0; #1; rst = 1'b1;
    req = 2'b11;
    step(); check("t3_first", gnt, 2'b01);
    m0_ss_n = 2'b10;
    step(); check("t3_xfer0", bus_ss_n, 5'b11110);
    m0_ss_n = 2'b11; req = 2'b10;
    step(); check("t3_rel0", gnt, 2'b00);
    req = 2'b11;
    for (int i = 0; i < 4; i++) step();
    check("t3_gap_end", gnt, 2'b00);
    step(); check("t3_second", gnt, 2'b10);
    check("t3_owner1", owner, 2'b10);

    // OWN1: the non-owner's selects and clock are masked.
    m1_ss_n = 3'b011; m0_ss_n = 2'b00; m0_sclk = 1'b1; m1_sclk = 1'b0; bus_miso = 1'b1; #1;
    check("t4_ss", bus_ss_n, 5'b01111);
    check("t4_sclk_lo", bus_sclk, 1'b0);
    m0_sclk = 1'b0; m1_sclk = 1'b1; m1_mosi = 1'b1; #1;
    check("t4_sclk_hi", bus_sclk, 1'b1);
    check("t4_mosi", bus_mosi, 1'b1);
    check("t4_miso", {m1_miso, m0_miso}, 2'b10);
    m0_sclk = 1'b1; #1;
    check("t4_sclk_m1", bus_sclk, 1'b1);
    m1_ss_n = 3'b111; m0_ss_n = 2'b11; m0_sclk = 1'b0; m1_sclk = 1'b0;
    m1_mosi = 1'b0; bus_miso = 1'b0; req = 2'b01;
    step(); check("t3_rel1", gnt, 2'b00);
    for (int i = 0; i < 4; i++) step();
    step(); check("t3_third", gnt, 2'b01);

    // Asynchronous reset in the middle of a requester 1 transfer.
    req = 2'b10;
    step(); check("t5_rel0", gnt, 2'b00);
    for (int i = 0; i < 4; i++) step();
    step(); check("t5_own1", gnt, 2'b10);
    m1_ss_n = 3'b110; m1_sclk = 1'b1; #1;
    check("t5_ss2_low", bus_ss_n, 5'b11011);
    rst = 1'b0; #1;
    check("t5_rst_ss", bus_ss_n, 5'b11111);
    check("t5_rst_sclk", bus_sclk, 1'b0);
    check("t5_rst_gnt", gnt, 2'b00);
    check("t5_rst_owner", owner, 2'b00);
    rst = 1'b1; m1_ss_n = 3'b111; m1_sclk = 1'b0; req = 2'b11;
    step(); check("t5_after_rst", gnt, 2'b01);

    // Grant length limit on requester 1.
    req = 2'b10;
    step(); check("t6_rel0", gnt, 2'b00);
    for (int i = 0; i < 4; i++) step();
    step(); check("t6_own1", gnt, 2'b10);
    m1_ss_n = 3'b110;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      step();
      check($sformatf("t6_held%0d", i), gnt, 2'b10);
    end
    check("t6_flag_pre", timeout_flag, 1'b0);
    step();
    check("t6_revoked", gnt, 2'b00);
    check("t6_flag", timeout_flag, 1'b1);
    check("t6_idle_ss", bus_ss_n, 5'b11111);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t6_guard%0d", i), gnt, 2'b00);
      check($sformatf("t6_guard_ss%0d", i), bus_ss_n, 5'b11111);
    end
    step();
    check("t6_regrant", gnt, 2'b10);
    check("t6_sticky", timeout_flag, 1'b1);
`else
    for (int i = 1; i < 21; i++) step();
    check("t6_no_revoke", gnt, 2'b10);
    check("t6_flag_off", timeout_flag, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
